// File: rtl/cpu_pkg.sv
// cpu_pkg: fault codes and controller state encoding shared by the call-stack blocks.
package cpu_pkg;
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;
endpackage

// File: rtl/call_stack_mem.sv
// call_stack_mem: return-address register file, synchronous write, asynchronous read.
module call_stack_mem #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [1<<AW];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: hardware return-address stack controller with overflow/underflow fault latch.
// Define CALL_STACK_WRAP_EN to let calls on a full stack overwrite the oldest entry instead of faulting.
module call_stack_ctrl
    import cpu_pkg::*;
#(
    parameter int CNTR_WIDTH  = 8,
    parameter int REG_BIT_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cal_f,
    input  logic                  ret_f,
    input  logic [CNTR_WIDTH-1:0] counter,
    input  logic                  clr_fault,
    output logic [CNTR_WIDTH-1:0] ret_addr,
    output logic                  ret_valid,
    output logic [REG_BIT_CNT:0]  depth,
    output logic                  full,
    output logic                  empty,
    output logic                  fault,
    output logic [1:0]            fault_code
);
    localparam logic [REG_BIT_CNT:0] D_CNT = (REG_BIT_CNT+1)'(1 << REG_BIT_CNT);

    state_t                 r_state, w_state_nxt;
    logic [REG_BIT_CNT-1:0] r_sp, w_sp_nxt, w_sp_m1, w_waddr;
    logic [REG_BIT_CNT:0]   r_depth, w_depth_nxt;
    logic [CNTR_WIDTH-1:0]  r_ret_addr, w_ret_addr_nxt, w_top;
    logic                   r_ret_valid, w_ret_valid_nxt, w_we, w_full, w_empty;
    logic [1:0]             r_fc, w_fc_nxt;

    assign w_sp_m1 = r_sp - 1'b1;
    assign w_full  = r_depth == D_CNT;
    assign w_empty = r_depth == '0;

    call_stack_mem #(.W(CNTR_WIDTH), .AW(REG_BIT_CNT)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (counter),
        .i_raddr (w_sp_m1),
        .o_rdata (w_top)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_sp_nxt        = r_sp;
        w_depth_nxt     = r_depth;
        w_ret_addr_nxt  = r_ret_addr;
        w_ret_valid_nxt = 1'b0;
        w_fc_nxt        = r_fc;
        w_we            = 1'b0;
        w_waddr         = r_sp;
        if (r_state == ST_FAULT) begin
            if (clr_fault) begin
                w_state_nxt = ST_RUN;
                w_sp_nxt    = '0;
                w_depth_nxt = '0;
                w_fc_nxt    = FC_NONE;
            end
        end else if (ret_f) begin
            if (w_empty) begin
                w_state_nxt = ST_FAULT;
                w_fc_nxt    = FC_UNF;
            end else begin
                w_ret_addr_nxt  = w_top;
                w_ret_valid_nxt = 1'b1;
                // a simultaneous call replaces the popped entry in place (tail call)
                if (cal_f) begin
                    w_we    = 1'b1;
                    w_waddr = w_sp_m1;
                end else begin
                    w_sp_nxt    = w_sp_m1;
                    w_depth_nxt = r_depth - 1'b1;
                end
            end
        end else if (cal_f) begin
`ifdef CALL_STACK_WRAP_EN
            w_we        = 1'b1;
            w_sp_nxt    = r_sp + 1'b1;
            w_depth_nxt = w_full ? r_depth : r_depth + 1'b1;
`else
            if (w_full) begin
                w_state_nxt = ST_FAULT;
                w_fc_nxt    = FC_OVF;
            end else begin
                w_we        = 1'b1;
                w_sp_nxt    = r_sp + 1'b1;
                w_depth_nxt = r_depth + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_sp        <= '0;
            r_depth     <= '0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_fc        <= FC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_sp        <= w_sp_nxt;
            r_depth     <= w_depth_nxt;
            r_ret_addr  <= w_ret_addr_nxt;
            r_ret_valid <= w_ret_valid_nxt;
            r_fc        <= w_fc_nxt;
        end
    end

    assign ret_addr   = r_ret_addr;
    assign ret_valid  = r_ret_valid;
    assign depth      = r_depth;
    assign full       = w_full;
    assign empty      = w_empty;
    assign fault      = r_state == ST_FAULT;
    assign fault_code = r_fc;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: scoreboard bench for call_stack_ctrl against a queue-based stack model.
// Follows CALL_STACK_WRAP_EN the same way as the design.
module tb_call_stack_ctrl;
    localparam int W = 8;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cal_f = 1'b0, ret_f = 1'b0, clr_fault = 1'b0;
    logic [W-1:0] counter = '0;
    logic [W-1:0] ret_addr;
    logic         ret_valid, full, empty, fault;
    logic [3:0]   depth;
    logic [1:0]   fault_code;

    call_stack_ctrl #(.CNTR_WIDTH(W), .REG_BIT_CNT(3)) dut (
        .clk(clk), .rst_n(rst_n), .cal_f(cal_f), .ret_f(ret_f), .counter(counter),
        .clr_fault(clr_fault), .ret_addr(ret_addr), .ret_valid(ret_valid), .depth(depth),
        .full(full), .empty(empty), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] stk[$];
    logic [W-1:0] exp_q[$];
    bit           m_fault = 1'b0;
    int           m_fc = 0;
    logic [W-1:0] m_ret = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of strobes and advance the abstract stack to what the next edge must produce
    task automatic cyc(input bit c, input bit r, input logic [W-1:0] v, input bit clr);
        @(negedge clk);
        #1;
        cal_f = c; ret_f = r; counter = v; clr_fault = clr;
        if (m_fault) begin
            if (clr) begin
                m_fault = 1'b0;
                m_fc = 0;
                stk.delete();
            end
        end else if (r) begin
            if (stk.size() == 0) begin
                m_fault = 1'b1;
                m_fc = 2;
            end else begin
                m_ret = stk[stk.size()-1];
                exp_q.push_back(m_ret);
                if (c) stk[stk.size()-1] = v;
                else void'(stk.pop_back());
            end
        end else if (c) begin
            if (stk.size() < D) stk.push_back(v);
            else begin
`ifdef CALL_STACK_WRAP_EN
                void'(stk.pop_front());
                stk.push_back(v);
`else
                m_fault = 1'b1;
                m_fc = 1;
`endif
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic model_reset();
        stk.delete();
        exp_q.delete();
        m_fault = 1'b0;
        m_fc = 0;
        m_ret = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_depth"}, int'(depth), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_code"}, int'(fault_code), 0);
        chk({tag, "_ret_addr"}, int'(ret_addr), 0);
        chk({tag, "_ret_valid"}, int'(ret_valid), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ret_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ret_valid: got ret_addr %0h expected no pulse at %0t", ret_addr, $time);
                end else chk("ret_pop", int'(ret_addr), int'(exp_q.pop_front()));
            end
            chk("ret_addr_hold", int'(ret_addr), int'(m_ret));
            chk("depth", int'(depth), stk.size());
            chk("full", int'(full), int'(stk.size() == D));
            chk("empty", int'(empty), int'(stk.size() == 0));
            chk("fault", int'(fault), int'(m_fault));
            chk("fault_code", int'(fault_code), m_fc);
        end
    end

    initial begin
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        #1 rst_n = 1'b1;
        // LIFO order
        cyc(1, 0, 8'h10, 0); cyc(1, 0, 8'h20, 0); cyc(1, 0, 8'h30, 0);
        cyc(0, 1, 8'h00, 0); cyc(0, 1, 8'h00, 0); cyc(0, 1, 8'h00, 0);
        idle(2);
        // fill, overflow, clear
        for (int i = 0; i < D + 1; i++) cyc(1, 0, 8'(8'h40 + i), 0);
        idle(1);
        cyc(0, 0, 8'h00, 1);
        idle(1);
        // drain whatever is left, then underflow and ignored call while faulted
        while (stk.size() > 0) cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(1, 0, 8'h77, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        // tail-call swap
        cyc(1, 0, 8'h05, 0);
        cyc(1, 1, 8'h44, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(1, 1, 8'h66, 0);
        cyc(0, 0, 8'h00, 1);
        idle(1);
        // wrap sequence 0x01..0x09 then nine pops
        for (int i = 1; i <= 9; i++) cyc(1, 0, 8'(i), 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'h00, 0);
        cyc(0, 0, 8'h00, 1);
        idle(1);
        // asynchronous reset mid-operation
        cyc(1, 0, 8'hA1, 0); cyc(1, 0, 8'hA2, 0); cyc(0, 1, 8'h00, 0);
        @(negedge clk);
        #1;
        cal_f = 1'b0; ret_f = 1'b0; clr_fault = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit c, r, clr;
            c = $urandom_range(0, 2) != 0;
            r = $urandom_range(0, 2) == 0;
            clr = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            cyc(c, r, 8'($urandom), clr);
        end
        idle(3);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
